// File: rtl/add_pkg.sv
// Shared definitions for the add pipeline stages: accumulator FSM states and
// width derivations, usable from both RTL and benches.
package add_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   // Wide enough for count full-scale samples, so the total never wraps.
   function automatic int unsigned acc_width(int unsigned width, int unsigned count);
      return width + $clog2(count);
   endfunction

   // Holds values 0..count inclusive.
   function automatic int unsigned cnt_width(int unsigned count);
      return $clog2(count) + 1;
   endfunction

endpackage

// File: rtl/add_accum.sv
// Accumulates COUNT consecutive sums from the add stage into a non-wrapping
// block total, presented on a registered valid/ready port; flush closes early.
module add_accum
   import add_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned COUNT = 4
)(
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [WIDTH-1:0]                    in_data,
   input  logic                                flush,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [acc_width(WIDTH, COUNT)-1:0]  out_sum,
   output logic [cnt_width(COUNT)-1:0]         out_count
);

   localparam int unsigned ACC_WIDTH = acc_width(WIDTH, COUNT);
   localparam int unsigned CNT_WIDTH = cnt_width(COUNT);

   generate
      if (COUNT < 2 || COUNT > 256) begin : g_bad_count
         $error("add_accum: COUNT must be in 2..256");
      end
   endgenerate

   state_t                 state, state_next;
   logic [ACC_WIDTH-1:0]   acc;
   logic [CNT_WIDTH-1:0]   cnt;

   logic                   accept;
   logic                   close_blk;
   logic [ACC_WIDTH-1:0]   sum_next;
   logic [CNT_WIDTH-1:0]   cnt_next;

   // Block closes on the final sample, or on flush when it holds or gains data.
   always_comb begin
      accept    = in_valid && in_ready;
      sum_next  = acc + (accept ? ACC_WIDTH'(in_data) : '0);
      cnt_next  = cnt + CNT_WIDTH'(accept);
      close_blk = (state == ACCUM) &&
                  ((accept && (cnt == CNT_WIDTH'(COUNT - 1))) ||
                   (flush && ((cnt != '0) || accept)));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ACCUM;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ACCUM: if (close_blk) state_next = HOLD;
         HOLD:  if (out_valid && out_ready) state_next = ACCUM;
         default: state_next = ACCUM;
      endcase
   end

   always_comb begin
      in_ready = (state == ACCUM);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
      end else if (state == ACCUM) begin
         if (close_blk) begin
            out_sum   <= sum_next;
            out_count <= cnt_next;
            out_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
         end else if (accept) begin
            acc <= sum_next;
            cnt <= cnt_next;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_add_accum.sv
// Self-checking bench for add_accum (WIDTH=8, COUNT=4): directed scenarios
// plus a randomized run against a block-level reference model.
module tb_add_accum;

   localparam int WIDTH = 8;
   localparam int COUNT = 4;
   localparam int ACC_W = add_pkg::acc_width(WIDTH, COUNT);
   localparam int CNT_W = add_pkg::cnt_width(COUNT);

   logic             clock;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_count;

   int checks = 0;
   int errors = 0;

   add_accum #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      flush    = 1'b0;
      in_data  = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; in_data = 8'hFF; flush = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0 || out_sum !== '0 || out_count !== '0) begin
            errors++;
            $display("FAIL reset_hold cyc%0d: valid=%b sum=%0d cnt=%0d required 0/0/0", i, out_valid, out_sum, out_count);
         end
      end
      reset = 1'b0; idle();
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      int exp_sum = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 8'(10 * (i + 1)); exp_sum += 10 * (i + 1);
         tick();
         if (i < 3) begin
            checks++;
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL b2b_early_valid sample%0d: out_valid=%b required 0", i, out_valid);
            end
         end
      end
      idle();
      checks++;
      if (out_valid !== 1'b1 || out_sum !== ACC_W'(exp_sum) || out_count !== CNT_W'(4) || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_result: valid=%b sum=%0d cnt=%0d rdy=%b required 1/%0d/4/0", out_valid, out_sum, out_count, in_ready, exp_sum);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_release: valid=%b rdy=%b required 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_max_values();
      out_ready = 1'b0;
      for (int pass = 0; pass < 2; pass++) begin
         int exp_sum = 0;
         for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'hFF; exp_sum += 255;
            tick();
            if (pass == 1 && i < 3) begin
               idle();
               repeat ($urandom_range(3, 1)) tick();
            end
         end
         idle();
         checks++;
         if (out_valid !== 1'b1 || out_sum !== ACC_W'(exp_sum) || out_count !== CNT_W'(4)) begin
            errors++;
            $display("FAIL max_values pass%0d: valid=%b sum=%0d cnt=%0d required 1/%0d/4", pass, out_valid, out_sum, out_count, exp_sum);
         end
         out_ready = 1'b1; tick(); out_ready = 1'b0;
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; in_data = 8'(i);
         tick();
      end
      in_valid = 1'b1; in_data = 8'd99;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_sum !== ACC_W'(10) || out_count !== CNT_W'(4) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold cyc%0d: valid=%b sum=%0d cnt=%0d rdy=%b required 1/10/4/0", i, out_valid, out_sum, out_count, in_ready);
         end
      end
      idle(); out_ready = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 8'd5;
         tick();
      end
      idle();
      checks++;
      if (out_valid !== 1'b1 || out_sum !== ACC_W'(20) || out_count !== CNT_W'(4)) begin
         errors++;
         $display("FAIL backpressure_next: valid=%b sum=%0d cnt=%0d required 1/20/4", out_valid, out_sum, out_count);
      end
      tick();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'd5; tick();
      in_data = 8'd7; tick();
      in_valid = 1'b0; flush = 1'b1; tick();
      idle();
      checks++;
      if (out_valid !== 1'b1 || out_sum !== ACC_W'(12) || out_count !== CNT_W'(2)) begin
         errors++;
         $display("FAIL flush_alone: valid=%b sum=%0d cnt=%0d required 1/12/2", out_valid, out_sum, out_count);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      in_valid = 1'b1; in_data = 8'd5; tick();
      in_data = 8'd7; tick();
      in_data = 8'd9; flush = 1'b1; tick();
      idle();
      checks++;
      if (out_valid !== 1'b1 || out_sum !== ACC_W'(21) || out_count !== CNT_W'(3)) begin
         errors++;
         $display("FAIL flush_with_accept: valid=%b sum=%0d cnt=%0d required 1/21/3", out_valid, out_sum, out_count);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== ACC_W'(21) || out_count !== CNT_W'(3)) begin
            errors++;
            $display("FAIL flush_empty cyc%0d: valid=%b rdy=%b sum=%0d cnt=%0d required 0/1/21/3", i, out_valid, in_ready, out_sum, out_count);
         end
      end
      idle();
      // A sample after the empty flushes must start a fresh block of one.
      in_valid = 1'b1; in_data = 8'd3; tick();
      in_valid = 1'b0; flush = 1'b1; tick(); idle();
      checks++;
      if (out_valid !== 1'b1 || out_sum !== ACC_W'(3) || out_count !== CNT_W'(1)) begin
         errors++;
         $display("FAIL flush_after_empty: valid=%b sum=%0d cnt=%0d required 1/3/1", out_valid, out_sum, out_count);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 8'(50 + 10 * i); tick();
      end
      idle(); reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 8'd1; tick();
      end
      idle();
      checks++;
      if (out_valid !== 1'b1 || out_sum !== ACC_W'(4) || out_count !== CNT_W'(4)) begin
         errors++;
         $display("FAIL reset_mid_block: valid=%b sum=%0d cnt=%0d required 1/4/4", out_valid, out_sum, out_count);
      end
      reset = 1'b1; tick(); reset = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0 || out_count !== '0) begin
         errors++;
         $display("FAIL reset_in_hold: valid=%b rdy=%b sum=%0d cnt=%0d required 0/1/0/0", out_valid, in_ready, out_sum, out_count);
      end
   endtask

   // Reference: the sink holds at most one pending block; samples are only
   // taken while nothing is pending, and a block ends at COUNT or on flush.
   task automatic test_random();
      bit pending = 0;
      int exp_sum = 0, exp_cnt = 0;
      int blk[$];
      reset = 1'b1; idle(); out_ready = 1'b0; tick(); reset = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         in_valid  = ($urandom_range(9, 0) < 7);
         in_data   = 8'($urandom);
         flush     = ($urandom_range(9, 0) == 0);
         out_ready = $urandom_range(1, 0) == 1;
         if (!pending) begin
            if (in_valid) blk.push_back(int'(in_data));
            if (blk.size() == COUNT || (flush && blk.size() > 0)) begin
               pending = 1;
               exp_sum = blk.sum();
               exp_cnt = blk.size();
               blk.delete();
            end
         end else if (out_ready) begin
            pending = 0;
         end
         tick();
         checks++;
         if (out_valid !== pending || in_ready !== !pending ||
             out_sum !== exp_sum[ACC_W-1:0] || out_count !== exp_cnt[CNT_W-1:0]) begin
            errors++;
            $display("FAIL random cyc%0d: valid=%b rdy=%b sum=%0d cnt=%0d required %b/%b/%0d/%0d",
                     cyc, out_valid, in_ready, out_sum, out_count, pending, !pending, exp_sum, exp_cnt);
         end
      end
      idle(); out_ready = 1'b1; tick();
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
      test_reset();
      test_back_to_back();
      test_max_values();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
